// File: rtl/sample_wave_gen.sv
// sample_wave_gen: phase-accumulator sample synthesiser with valid/ready output and ideal square reference
module sample_wave_gen #(
    parameter int DROP_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stop,
    input  logic [31:0]       cfg_phase_inc,
    input  logic [15:0]       cfg_amplitude,
    input  logic [31:0]       cfg_offset,
    input  logic [1:0]        cfg_shape,
    input  logic [15:0]       cfg_div,
    output logic [31:0]       sample_out,
    output logic              sample_valid,
    input  logic              sample_ready,
    output logic              square_ref,
    output logic              busy,
    output logic              saturated,
    output logic [DROP_W-1:0] dropped_cnt
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    localparam logic signed [33:0] S_MAX = 34'sd2147483647;
    localparam logic signed [33:0] S_MIN = -34'sd2147483648;

    state_t             state, state_nxt;
    logic [31:0]        inc_r, off_r, phase;
    logic [15:0]        amp_r, div_r, div_cnt;
    logic [1:0]         shape_r;
    logic               tick, accept, load, drop;
    logic [14:0]        q;
    logic signed [16:0] q_s, w;
    logic signed [33:0] p, s;
    logic               clip_hi, clip_lo;
    logic [31:0]        s_clip;

    assign tick   = state == RUN && div_cnt == div_r;
    assign accept = sample_valid && sample_ready;
    assign load   = tick && (!sample_valid || accept);
    assign drop   = tick && sample_valid && !sample_ready;
    assign busy   = state != IDLE;

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // next state: DRAIN leaves once nothing is pending or the pending sample transfers
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? RUN : IDLE;
            RUN:     state_nxt = stop ? DRAIN : RUN;
            DRAIN:   state_nxt = (!sample_valid || accept) ? IDLE : DRAIN;
            default: state_nxt = IDLE;
        endcase
    end

    // waveform value from phase, scaled by amplitude, offset and clamped to 32 bits
    always_comb begin
        q       = phase[30:16];
        q_s     = signed'({2'b00, q});
        w       = cfg_shape_val(shape_r, phase[31], q_s, phase[31:17]);
        p       = $signed({18'd0, amp_r}) * $signed({{17{w[16]}}, w});
        s       = $signed({{2{off_r[31]}}, off_r}) + (p >>> 14);
        clip_hi = s > S_MAX;
        clip_lo = s < S_MIN;
        s_clip  = clip_hi ? 32'h7FFF_FFFF : clip_lo ? 32'h8000_0000 : s[31:0];
    end

    function automatic logic signed [16:0] cfg_shape_val(input logic [1:0] sh, input logic neg,
                                                         input logic signed [16:0] qv, input logic [14:0] saw);
        return sh == 2'd0 ? (neg ? -17'sd16384 : 17'sd16384) :
               sh == 2'd1 ? (neg ? 17'sd16383 - qv : qv - 17'sd16384) :
               sh == 2'd2 ? signed'({{2{saw[14]}}, saw}) : 17'sd0;
    endfunction

    // config latch, phase accumulator and sample-rate divider
    always_ff @(posedge clk) begin
        if (rst) begin
            inc_r   <= '0;
            off_r   <= '0;
            amp_r   <= '0;
            div_r   <= '0;
            shape_r <= '0;
            phase   <= '0;
            div_cnt <= '0;
        end else if (state == IDLE && start) begin
            inc_r   <= cfg_phase_inc;
            off_r   <= cfg_offset;
            amp_r   <= cfg_amplitude;
            div_r   <= cfg_div;
            shape_r <= cfg_shape;
            phase   <= '0;
            div_cnt <= '0;
        end else if (state == RUN) begin
            div_cnt <= tick ? '0 : div_cnt + 16'd1;
            if (tick) phase <= phase + inc_r;
        end
    end

    // output register, handshake, sticky saturation and saturating drop counter
    always_ff @(posedge clk) begin
        if (rst) begin
            sample_out   <= '0;
            sample_valid <= 1'b0;
            square_ref   <= 1'b1;
            saturated    <= 1'b0;
            dropped_cnt  <= '0;
        end else begin
            if (state == IDLE && start) begin
                saturated   <= 1'b0;
                dropped_cnt <= '0;
            end
            if (load) begin
                sample_out   <= s_clip;
                square_ref   <= ~phase[31];
                sample_valid <= 1'b1;
                if (clip_hi || clip_lo) saturated <= 1'b1;
            end else if (accept) begin
                sample_valid <= 1'b0;
            end
            if (drop && dropped_cnt != '1) dropped_cnt <= dropped_cnt + DROP_W'(1);
        end
    end
endmodule

// File: tb/tb_sample_wave_gen.sv
// tb_sample_wave_gen: table-driven and directed checks of sample_wave_gen
module tb_sample_wave_gen;
    logic        clk = 1'b0;
    logic        rst = 1'b1, start = 1'b0, stop = 1'b0, sample_ready = 1'b0;
    logic [31:0] cfg_phase_inc = '0, cfg_offset = '0;
    logic [15:0] cfg_amplitude = '0, cfg_div = '0;
    logic [1:0]  cfg_shape = '0;
    logic [31:0] sample_out;
    logic        sample_valid, square_ref, busy, saturated;
    logic [7:0]  dropped_cnt;
    int          pass_cnt = 0, total = 0;

    typedef struct {
        logic [1:0]        shape;
        logic [15:0]       amp;
        logic [31:0]       off;
        logic [31:0]       inc;
        logic [0:7][31:0]  exp;
        logic [0:7]        sq;
        logic              sat;
    } vec_t;

    vec_t vecs [6];

    sample_wave_gen #(.DROP_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop),
        .cfg_phase_inc(cfg_phase_inc), .cfg_amplitude(cfg_amplitude), .cfg_offset(cfg_offset),
        .cfg_shape(cfg_shape), .cfg_div(cfg_div),
        .sample_out(sample_out), .sample_valid(sample_valid), .sample_ready(sample_ready),
        .square_ref(square_ref), .busy(busy), .saturated(saturated), .dropped_cnt(dropped_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else pass_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [1:0] sh, input logic [15:0] a, input logic [31:0] o,
                            input logic [31:0] inc, input logic [15:0] d);
        cfg_shape = sh; cfg_amplitude = a; cfg_offset = o; cfg_phase_inc = inc; cfg_div = d;
        start = 1'b1;
        step();
        start = 1'b0;
        cfg_shape = 2'd3; cfg_amplitude = 16'hFFFF; cfg_offset = 32'h1234_5678; cfg_phase_inc = 32'h0; cfg_div = 16'd7;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 20 && busy; i++) step();
        chk("drain_timeout", busy, 0);
    endtask

    task automatic run_row(input vec_t v, input int r);
        sample_ready = 1'b1;
        do_start(v.shape, v.amp, v.off, v.inc, 16'd0);
        chk($sformatf("r%0d_busy", r), busy, 1);
        chk($sformatf("r%0d_sat_clr", r), saturated, 0);
        chk($sformatf("r%0d_drop_clr", r), dropped_cnt, 0);
        chk($sformatf("r%0d_valid_c1", r), sample_valid, 0);
        step();
        for (int k = 0; k < 8; k++) begin
            chk($sformatf("r%0d_valid%0d", r, k), sample_valid, 1);
            chk($sformatf("r%0d_out%0d", r, k), sample_out, v.exp[k]);
            chk($sformatf("r%0d_sq%0d", r, k), square_ref, v.sq[k]);
            if (k < 7) step();
        end
        chk($sformatf("r%0d_sat", r), saturated, v.sat);
        chk($sformatf("r%0d_drop", r), dropped_cnt, 0);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle();
        chk($sformatf("r%0d_idle_valid", r), sample_valid, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 16'd1000, 32'd0, 32'h4000_0000,
                    {32'd1000, 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FC18, 32'd1000, 32'd1000, 32'hFFFF_FC18, 32'hFFFF_FC18},
                    8'b1100_1100, 1'b0};
        vecs[1] = '{2'd1, 16'd16384, 32'd0, 32'h2000_0000,
                    {32'hFFFF_C000, 32'hFFFF_E000, 32'd0, 32'h0000_2000, 32'h0000_3FFF, 32'h0000_1FFF, 32'hFFFF_FFFF, 32'hFFFF_DFFF},
                    8'b1111_0000, 1'b0};
        vecs[2] = '{2'd2, 16'd16384, 32'd0, 32'h2000_0000,
                    {32'd0, 32'h0000_1000, 32'h0000_2000, 32'h0000_3000, 32'hFFFF_C000, 32'hFFFF_D000, 32'hFFFF_E000, 32'hFFFF_F000},
                    8'b1111_0000, 1'b0};
        vecs[3] = '{2'd3, 16'd1000, 32'hFFFF_FFFB, 32'h4000_0000,
                    {32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB},
                    8'b1100_1100, 1'b0};
        vecs[4] = '{2'd0, 16'd1000, 32'h7FFF_FF00, 32'h8000_0000,
                    {32'h7FFF_FFFF, 32'h7FFF_FB18, 32'h7FFF_FFFF, 32'h7FFF_FB18, 32'h7FFF_FFFF, 32'h7FFF_FB18, 32'h7FFF_FFFF, 32'h7FFF_FB18},
                    8'b1010_1010, 1'b1};
        vecs[5] = '{2'd0, 16'd1000, 32'h8000_0100, 32'h8000_0000,
                    {32'h8000_04E8, 32'h8000_0000, 32'h8000_04E8, 32'h8000_0000, 32'h8000_04E8, 32'h8000_0000, 32'h8000_04E8, 32'h8000_0000},
                    8'b1010_1010, 1'b1};

        step();
        step();
        chk("rst_out", sample_out, 0);
        chk("rst_valid", sample_valid, 0);
        chk("rst_sq", square_ref, 1);
        chk("rst_busy", busy, 0);
        chk("rst_sat", saturated, 0);
        chk("rst_drop", dropped_cnt, 0);
        rst = 1'b0;
        step();

        for (int r = 0; r < 6; r++) run_row(vecs[r], r);

        sample_ready = 1'b0;
        do_start(2'd0, 16'd1000, 32'd0, 32'h4000_0000, 16'd1);
        step();
        chk("bp_c2_valid", sample_valid, 0);
        step();
        for (int c = 3; c <= 12; c++) begin
            chk($sformatf("bp_valid_c%0d", c), sample_valid, 1);
            chk($sformatf("bp_out_c%0d", c), sample_out, 32'd1000);
            step();
        end
        chk("bp_drop5", dropped_cnt, 5);
        chk("bp_out_c13", sample_out, 32'd1000);
        sample_ready = 1'b1;
        step();
        chk("bp_valid_c14", sample_valid, 0);
        step();
        chk("bp_valid_c15", sample_valid, 1);
        chk("bp_phase_out", sample_out, 32'hFFFF_FC18);
        chk("bp_phase_sq", square_ref, 0);
        sample_ready = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        for (int c = 16; c <= 19; c++) begin
            chk($sformatf("dr_busy_c%0d", c), busy, 1);
            chk($sformatf("dr_valid_c%0d", c), sample_valid, 1);
            chk($sformatf("dr_out_c%0d", c), sample_out, 32'hFFFF_FC18);
            chk($sformatf("dr_drop_c%0d", c), dropped_cnt, 5);
            if (c < 19) step();
        end
        sample_ready = 1'b1;
        step();
        sample_ready = 1'b0;
        chk("dr_busy_after", busy, 0);
        chk("dr_valid_after", sample_valid, 0);
        step();
        step();
        chk("dr_no_more", sample_valid, 0);

        sample_ready = 1'b1;
        cfg_shape = 2'd0; cfg_amplitude = 16'd1000; cfg_offset = 32'd0; cfg_phase_inc = 32'h4000_0000; cfg_div = 16'd0;
        start = 1'b1; stop = 1'b1;
        step();
        start = 1'b0; stop = 1'b0;
        chk("ss_busy", busy, 1);
        step();
        chk("ss_out0", sample_out, 32'd1000);
        cfg_amplitude = 16'd2000; cfg_phase_inc = 32'h8000_0000;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run_start_ign1", sample_out, 32'd1000);
        step();
        chk("run_start_ign2", sample_out, 32'hFFFF_FC18);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle();
        stop = 1'b1;
        step();
        stop = 1'b0;
        chk("idle_stop_ign", busy, 0);
        step();
        chk("idle_stop_ign2", busy, 0);

        sample_ready = 1'b1;
        do_start(2'd0, 16'd1000, 32'h7FFF_FF00, 32'h8000_0000, 16'd0);
        step();
        step();
        sample_ready = 1'b0;
        repeat (300) step();
        chk("dsat_drop", dropped_cnt, 8'hFF);
        chk("dsat_sat", saturated, 1);
        chk("dsat_out", sample_out, 32'h7FFF_FB18);
        chk("dsat_sq", square_ref, 0);
        chk("dsat_busy", busy, 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mrst_out", sample_out, 0);
        chk("mrst_valid", sample_valid, 0);
        chk("mrst_sq", square_ref, 1);
        chk("mrst_busy", busy, 0);
        chk("mrst_sat", saturated, 0);
        chk("mrst_drop", dropped_cnt, 0);
        sample_ready = 1'b1;
        do_start(2'd0, 16'd1000, 32'd0, 32'h4000_0000, 16'd0);
        step();
        chk("re_out0", sample_out, 32'd1000);
        step();
        chk("re_out1", sample_out, 32'd1000);
        step();
        chk("re_out2", sample_out, 32'hFFFF_FC18);
        step();
        chk("re_out3", sample_out, 32'hFFFF_FC18);
        stop = 1'b1;
        step();
        stop = 1'b0;
        wait_idle();

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
